mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Parametrised successor to the two-port instruction/data memory front end.
- Arbitrates NUM_CH requesters onto the single main-memory port. Default: ch0 = dmem, ch1 = imem.
- Registered request capture, selectable fixed-priority or round-robin arbitration, per-channel ack handshake and a bus timeout.
- Sits between core fetch/LSU ports and the main memory model/controller.

Parameters:
- NUM_CH, 2, number of requester channels (>=2).
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- ARB_MODE, 0, 0 = fixed priority (lowest index wins); 1 = round-robin.
- TIMEOUT_CYC, 255, BUSY cycles before abort; 0 disables the timeout.

Ports:
- clk, in, 1, system clock, rising edge.
- rst, in, 1, reset, synchronous, active-low.
- req, in, NUM_CH, per-channel transaction request.
- we, in, NUM_CH, per-channel write enable (1 = write, 0 = read).
- addr, in, NUM_CH*ADDR_W, packed per-channel address; ch i at [i*ADDR_W +: ADDR_W].
- wdata, in, NUM_CH*DATA_W, packed per-channel write data.
- ack, out, NUM_CH, one-cycle completion pulse to the owning channel.
- err, out, 1, one-cycle pulse coincident with ack when the transaction timed out.
- rdata, out, DATA_W, registered read data, valid while ack is asserted.
- mem_re, out, 1, memory read strobe.
- mem_wr, out, 1, memory write strobe.
- mem_addr, out, ADDR_W, memory address.
- mem_wdata, out, DATA_W, memory write data.
- mem_rdata, in, DATA_W, memory read data.
- mem_ready, in, 1, memory completion, sampled in BUSY only.

Behaviour:
- Reset (rst = 0 at a clk edge):
  - State goes to IDLE.
  - ack, err, rdata, mem_re, mem_wr, mem_addr and mem_wdata are all 0.
  - The round-robin pointer is set to last = NUM_CH-1, so ch0 wins first.
  - Timeout counter is 0.
  - Reset mid-transaction drops it: no ack is issued and the memory strobes deassert on the next edge.
- State IDLE:
  - With req != 0, select winner w.
  - ARB_MODE 0: w is the lowest set index.
  - ARB_MODE 1: w is the first set index scanning from last+1 with wrap-around; then last := w.
  - On the same edge: sel := w; mem_addr := addr[w]; mem_wdata := we[w] ? wdata[w] : 0; mem_re := ~we[w]; mem_wr := we[w]; go to BUSY.
  - With req == 0, remain in IDLE with the strobes at 0.
- State BUSY:
  - mem_re, mem_wr, mem_addr and mem_wdata are held stable.
  - The counter increments each cycle.
  - On mem_ready = 1:
    - ack[sel] := 1 for one cycle.
    - rdata := mem_rdata on a read, 0 on a write.
    - Strobes := 0; counter := 0; go to IDLE.
  - Timeout: TIMEOUT_CYC != 0, the counter reaches TIMEOUT_CYC-1 and mem_ready = 0:
    - ack[sel] := 1 and err := 1.
    - rdata := 0; strobes := 0; go to IDLE.
  - mem_ready and timeout on the same cycle: normal completion, err = 0.
- Latency:
  - req to mem strobe: 1 cycle.
  - mem_ready to ack: 1 cycle.
  - Minimum transaction is 3 cycles, including the IDLE re-arbitration cycle.
  - Back-to-back requests from one channel get one IDLE cycle between them.
- Requester contract:
  - Hold req, we, addr and wdata until ack.
  - Inputs are captured at grant, so changes made while BUSY are ignored.
  - req dropped while BUSY still completes and still acks.
- Other boundaries:
  - ack is at most one-hot and is never asserted in IDLE with a stale sel.
  - mem_ready while IDLE is ignored.
  - Round-robin pointer wraps NUM_CH-1 -> 0.
  - The pointer only updates on a grant.

Decomposition:
- Shared package mem_pkg:
  - State enum: IDLE, BUSY.
  - ARB_FIXED = 0 and ARB_RR = 1.
  - Default widths ADDR_W/DATA_W = 32.
- One natural sub-module, rr_arbiter:
  - Combinational winner select from req, last and ARB_MODE.
  - Outputs a one-hot grant plus a binary index.
  - Parametrised on NUM_CH.
- The FSM, capture registers and timeout counter stay in mem_arbiter.

Test Plan:
- Single read: rst released; req = 01, we = 00, addr0 = 0x100; mem_ready = 1 two cycles later with mem_rdata = 0xDEADBEEF -> mem_re = 1 and mem_addr = 0x100 from cycle 1; ack = 01 and rdata = 0xDEADBEEF one cycle after mem_ready.
- Single write: ch1 we = 1, addr = 0x200, wdata = 0x12345678, mem_ready after 3 cycles -> mem_wr = 1 with stable addr and data for all BUSY cycles; ack = 10, rdata = 0, err = 0.
- Fixed priority: ARB_MODE = 0, req = 11 held continuously, memory always ready -> ch0 granted every transaction; ch1 starves; ack is never 10.
- Round-robin: ARB_MODE = 1, NUM_CH = 4, req = 1111 held -> grant order 0, 1, 2, 3, 0; pointer wraps.
- Timeout: TIMEOUT_CYC = 8, mem_ready held 0 -> after 8 BUSY cycles, ack[sel] = 1, err = 1, strobes drop, FSM returns to IDLE.
- Reset mid-BUSY: rst = 0 on the 2nd BUSY cycle -> next edge all outputs are 0; no ack; after release, ch0 (pending) is re-granted first.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and constants for the memory arbiter.
package mem_pkg;

    // Arbiter FSM states.
    typedef enum logic {
        StIdle = 1'b0,
        StBusy = 1'b1
    } state_e;

    // Arbitration policies.
    localparam int unsigned ARB_FIXED = 0;
    localparam int unsigned ARB_RR    = 1;

    // Default bus widths.
    localparam int unsigned ADDR_W_DEF = 32;
    localparam int unsigned DATA_W_DEF = 32;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational winner select: fixed priority (lowest index) or round-robin from last+1.
module rr_arbiter
    import mem_pkg::*;
#(
    parameter int unsigned NUM_CH   = 2,
    parameter int unsigned ARB_MODE = ARB_FIXED,
    localparam int unsigned IdxW    = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req_i,
    input  logic [IdxW-1:0]   last_i,
    output logic [NUM_CH-1:0] gnt_o,
    output logic [IdxW-1:0]   idx_o,
    output logic              valid_o
);

    // Scan the channels in priority order and keep the first requester found.
    always_comb begin
        int unsigned j;
        idx_o   = '0;
        valid_o = 1'b0;
        j       = 0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            if (ARB_MODE == ARB_RR) begin
                j = (int'(last_i) + k + 1) % NUM_CH;
            end else begin
                j = k;
            end
            if (!valid_o && req_i[j]) begin
                valid_o = 1'b1;
                idx_o   = IdxW'(j);
            end
        end
    end

    assign gnt_o = valid_o ? (NUM_CH'(1) << idx_o) : '0;

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates NUM_CH requesters onto one main-memory port with per-channel ack and a bus timeout.
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int unsigned NUM_CH      = 2,
    parameter int unsigned ADDR_W      = ADDR_W_DEF,
    parameter int unsigned DATA_W      = DATA_W_DEF,
    parameter int unsigned ARB_MODE    = ARB_FIXED,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [NUM_CH-1:0]        req_i,
    input  logic [NUM_CH-1:0]        we_i,
    input  logic [NUM_CH*ADDR_W-1:0] addr_i,
    input  logic [NUM_CH*DATA_W-1:0] wdata_i,
    output logic [NUM_CH-1:0]        ack_o,
    output logic                     err_o,
    output logic [DATA_W-1:0]        rdata_o,
    output logic                     mem_re_o,
    output logic                     mem_wr_o,
    output logic [ADDR_W-1:0]        mem_addr_o,
    output logic [DATA_W-1:0]        mem_wdata_o,
    input  logic [DATA_W-1:0]        mem_rdata_i,
    input  logic                     mem_ready_i
);

    localparam int unsigned IdxW = $clog2(NUM_CH);
    localparam int unsigned CntW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    // Only meaningful when the timeout is enabled; the compare below is gated on that.
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYC - 1);

    state_e              state_q, state_d;
    logic [NUM_CH-1:0]   sel_q, sel_d;
    logic [IdxW-1:0]     last_q, last_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic                re_q, re_d;
    logic                wr_q, wr_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [NUM_CH-1:0]   ack_q, ack_d;
    logic                err_q, err_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;

    logic [NUM_CH-1:0]   win_gnt;
    logic [IdxW-1:0]     win_idx;
    logic                win_valid;
    logic                timeout;

    rr_arbiter #(
        .NUM_CH   (NUM_CH),
        .ARB_MODE (ARB_MODE)
    ) u_rr_arbiter (
        .req_i   (req_i),
        .last_i  (last_q),
        .gnt_o   (win_gnt),
        .idx_o   (win_idx),
        .valid_o (win_valid)
    );

    assign timeout = (TIMEOUT_CYC != 0) && (cnt_q == CntLast);

    // Next-state: grant and capture in IDLE, wait for completion or timeout in BUSY.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        re_d    = re_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        ack_d   = '0;
        err_d   = 1'b0;
        rdata_d = '0;
        unique case (state_q)
            StIdle: begin
                if (win_valid) begin
                    sel_d   = win_gnt;
                    addr_d  = addr_i[win_idx*ADDR_W +: ADDR_W];
                    wdata_d = we_i[win_idx] ? wdata_i[win_idx*DATA_W +: DATA_W] : '0;
                    re_d    = ~we_i[win_idx];
                    wr_d    = we_i[win_idx];
                    cnt_d   = '0;
                    state_d = StBusy;
                    if (ARB_MODE == ARB_RR) begin
                        last_d = win_idx;
                    end
                end
            end
            StBusy: begin
                // A ready on the timeout cycle still counts as a normal completion.
                if (mem_ready_i) begin
                    ack_d   = sel_q;
                    rdata_d = re_q ? mem_rdata_i : '0;
                    re_d    = 1'b0;
                    wr_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = StIdle;
                end else if (timeout) begin
                    ack_d   = sel_q;
                    err_d   = 1'b1;
                    re_d    = 1'b0;
                    wr_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            sel_q   <= '0;
            last_q  <= IdxW'(NUM_CH - 1);
            cnt_q   <= '0;
            re_q    <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            ack_q   <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            re_q    <= re_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    assign ack_o       = ack_q;
    assign err_o       = err_q;
    assign rdata_o     = rdata_q;
    assign mem_re_o    = re_q;
    assign mem_wr_o    = wr_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench: instance 0 = 2-ch fixed priority, timeout 8; instance 1 = 4-ch round-robin, no timeout.
module tb_mem_arbiter;

    typedef struct {
        int          inst;
        int          ch;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        int          busy;
    } exp_t;

    logic clk;
    logic rst_n;

    logic [3:0]   req   [2];
    logic [3:0]   we    [2];
    logic [127:0] addr  [2];
    logic [127:0] wdata [2];
    logic         mready [2];
    logic [31:0]  mrdata [2];
    logic         force_rdy [2];

    logic [1:0]  ack0;
    logic [3:0]  ack1;
    logic        err0, err1, re0, re1, wr0, wr1;
    logic [31:0] rdata0, rdata1, maddr0, maddr1, mwdata0, mwdata1;

    logic [3:0]  ack_v    [2];
    logic        err_v    [2];
    logic        re_v     [2];
    logic        wr_v     [2];
    logic [31:0] rdata_v  [2];
    logic [31:0] maddr_v  [2];
    logic [31:0] mwdata_v [2];

    int   busy_cnt [2];
    int   lat      [2];
    int   hold_cnt [2];
    exp_t sb [$];
    int   n_vec;
    int   n_err;

    mem_arbiter #(
        .NUM_CH      (2),
        .ADDR_W      (32),
        .DATA_W      (32),
        .ARB_MODE    (0),
        .TIMEOUT_CYC (8)
    ) u_dut0 (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_i       (req[0][1:0]),
        .we_i        (we[0][1:0]),
        .addr_i      (addr[0][63:0]),
        .wdata_i     (wdata[0][63:0]),
        .ack_o       (ack0),
        .err_o       (err0),
        .rdata_o     (rdata0),
        .mem_re_o    (re0),
        .mem_wr_o    (wr0),
        .mem_addr_o  (maddr0),
        .mem_wdata_o (mwdata0),
        .mem_rdata_i (mrdata[0]),
        .mem_ready_i (mready[0])
    );

    mem_arbiter #(
        .NUM_CH      (4),
        .ADDR_W      (32),
        .DATA_W      (32),
        .ARB_MODE    (1),
        .TIMEOUT_CYC (0)
    ) u_dut1 (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_i       (req[1]),
        .we_i        (we[1]),
        .addr_i      (addr[1]),
        .wdata_i     (wdata[1]),
        .ack_o       (ack1),
        .err_o       (err1),
        .rdata_o     (rdata1),
        .mem_re_o    (re1),
        .mem_wr_o    (wr1),
        .mem_addr_o  (maddr1),
        .mem_wdata_o (mwdata1),
        .mem_rdata_i (mrdata[1]),
        .mem_ready_i (mready[1])
    );

    always_comb begin
        ack_v[0]    = {2'b00, ack0};
        ack_v[1]    = ack1;
        err_v[0]    = err0;
        err_v[1]    = err1;
        re_v[0]     = re0;
        re_v[1]     = re1;
        wr_v[0]     = wr0;
        wr_v[1]     = wr1;
        rdata_v[0]  = rdata0;
        rdata_v[1]  = rdata1;
        maddr_v[0]  = maddr0;
        maddr_v[1]  = maddr1;
        mwdata_v[0] = mwdata0;
        mwdata_v[1] = mwdata1;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int inst, input int ch, input logic w, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] rd, input logic e_err,
                        input int busy);
        exp_t e;
        e.inst  = inst;
        e.ch    = ch;
        e.we    = w;
        e.addr  = a;
        e.wdata = w ? wd : 32'h0;
        e.rdata = (e_err || w) ? 32'h0 : rd;
        e.err   = e_err;
        e.busy  = busy;
        sb.push_back(e);
    endtask

    task automatic drive_req(input int i, input int ch, input logic w, input logic [31:0] a,
                             input logic [31:0] wd);
        req[i][ch]            = 1'b1;
        we[i][ch]             = w;
        addr[i][ch*32 +: 32]  = a;
        wdata[i][ch*32 +: 32] = wd;
    endtask

    // One cycle: sample at negedge, score acks and strobes, then drive requesters and memory.
    task automatic step();
        exp_t e;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            if (ack_v[i] != 4'b0000) begin
                if (sb.size() == 0 || sb[0].inst != i) begin
                    check("ack_unexpected", 64'(ack_v[i]), 64'h0);
                end else begin
                    e = sb.pop_front();
                    check("ack", 64'(ack_v[i]), 64'(1) << e.ch);
                    check("err", 64'(err_v[i]), 64'(e.err));
                    check("rdata", 64'(rdata_v[i]), 64'(e.rdata));
                    check("busy_len", 64'(busy_cnt[i]), 64'(e.busy));
                    check("strobe_drop", 64'({re_v[i], wr_v[i]}), 64'h0);
                    if (hold_cnt[i] > 0) begin
                        hold_cnt[i]--;
                        if (hold_cnt[i] == 0) req[i] = 4'b0000;
                    end else begin
                        req[i][e.ch] = 1'b0;
                    end
                end
            end
            if (re_v[i] || wr_v[i]) begin
                if (sb.size() == 0 || sb[0].inst != i) begin
                    check("strobe_unexpected", 64'({re_v[i], wr_v[i]}), 64'h0);
                end else begin
                    check("mem_addr", 64'(maddr_v[i]), 64'(sb[0].addr));
                    check("mem_wdata", 64'(mwdata_v[i]), 64'(sb[0].wdata));
                    check("mem_re", 64'(re_v[i]), 64'(!sb[0].we));
                    check("mem_wr", 64'(wr_v[i]), 64'(sb[0].we));
                end
            end
            busy_cnt[i] = (re_v[i] || wr_v[i]) ? busy_cnt[i] + 1 : 0;
            mready[i]   = force_rdy[i] || (lat[i] != 0 && busy_cnt[i] == lat[i]);
        end
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            step();
            n++;
        end
        check("drain", 64'(sb.size()), 64'h0);
        step();
    endtask

    task automatic check_zero(input int i, input string tag);
        check({tag, "_ack"}, 64'(ack_v[i]), 64'h0);
        check({tag, "_err"}, 64'(err_v[i]), 64'h0);
        check({tag, "_rdata"}, 64'(rdata_v[i]), 64'h0);
        check({tag, "_re"}, 64'(re_v[i]), 64'h0);
        check({tag, "_wr"}, 64'(wr_v[i]), 64'h0);
        check({tag, "_maddr"}, 64'(maddr_v[i]), 64'h0);
        check({tag, "_mwdata"}, 64'(mwdata_v[i]), 64'h0);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            req[i]       = '0;
            we[i]        = '0;
            addr[i]      = '0;
            wdata[i]     = '0;
            mready[i]    = 1'b0;
            mrdata[i]    = '0;
            force_rdy[i] = 1'b0;
            lat[i]       = 0;
            hold_cnt[i]  = 0;
        end

        // Reset state.
        repeat (3) step();
        check_zero(0, "rst0");
        check_zero(1, "rst1");
        rst_n = 1'b1;
        step();

        // Single read on ch0, ready on the 2nd BUSY cycle.
        mrdata[0] = 32'hDEADBEEF;
        lat[0]    = 2;
        drive_req(0, 0, 1'b0, 32'h100, 32'h0);
        push(0, 0, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 1'b0, 2);
        wait_done(20);

        // Single write on ch1; request inputs change after grant and must be ignored.
        lat[0] = 3;
        drive_req(0, 1, 1'b1, 32'h200, 32'h12345678);
        push(0, 1, 1'b1, 32'h200, 32'h12345678, 32'hDEADBEEF, 1'b0, 3);
        step();
        addr[0][63:32]  = 32'h0BAD0BAD;
        wdata[0][63:32] = 32'h55555555;
        wait_done(20);

        // Fixed priority: both held, memory ready at once, ch0 wins every time.
        lat[0]      = 1;
        mrdata[0]   = 32'hA5A50001;
        hold_cnt[0] = 3;
        drive_req(0, 0, 1'b0, 32'h300, 32'h0);
        drive_req(0, 1, 1'b0, 32'h304, 32'h0);
        for (int k = 0; k < 3; k++) push(0, 0, 1'b0, 32'h300, 32'h0, 32'hA5A50001, 1'b0, 1);
        wait_done(40);

        // mem_ready while IDLE is ignored.
        force_rdy[0] = 1'b1;
        repeat (3) step();
        force_rdy[0] = 1'b0;
        check("idle_ready_ack", 64'(ack_v[0]), 64'h0);
        check("idle_ready_re", 64'(re_v[0]), 64'h0);

        // Timeout: memory never ready, abort after 8 BUSY cycles.
        lat[0] = 0;
        drive_req(0, 1, 1'b0, 32'h500, 32'h0);
        push(0, 1, 1'b0, 32'h500, 32'h0, 32'h0, 1'b1, 8);
        wait_done(40);

        // Round-robin, all four held: order 0,1,2,3 then wrap to 0.
        lat[1]      = 1;
        mrdata[1]   = 32'h55550000;
        hold_cnt[1] = 5;
        for (int c = 0; c < 4; c++) drive_req(1, c, 1'b0, 32'h1000 + 32'(c * 4), 32'h0);
        push(1, 0, 1'b0, 32'h1000, 32'h0, 32'h55550000, 1'b0, 1);
        push(1, 1, 1'b0, 32'h1004, 32'h0, 32'h55550000, 1'b0, 1);
        push(1, 2, 1'b0, 32'h1008, 32'h0, 32'h55550000, 1'b0, 1);
        push(1, 3, 1'b0, 32'h100C, 32'h0, 32'h55550000, 1'b0, 1);
        push(1, 0, 1'b0, 32'h1000, 32'h0, 32'h55550000, 1'b0, 1);
        wait_done(60);

        // Round-robin on a sparse mask after last=0: 1, 2, then wrap back to 1.
        hold_cnt[1] = 3;
        drive_req(1, 1, 1'b1, 32'h2004, 32'h11110001);
        drive_req(1, 2, 1'b0, 32'h2008, 32'h0);
        push(1, 1, 1'b1, 32'h2004, 32'h11110001, 32'h55550000, 1'b0, 1);
        push(1, 2, 1'b0, 32'h2008, 32'h0, 32'h55550000, 1'b0, 1);
        push(1, 1, 1'b1, 32'h2004, 32'h11110001, 32'h55550000, 1'b0, 1);
        wait_done(40);

        // Timeout disabled: a 20-cycle memory stall completes normally.
        lat[1]    = 20;
        mrdata[1] = 32'h0F0F0F0F;
        drive_req(1, 3, 1'b0, 32'h3000, 32'h0);
        push(1, 3, 1'b0, 32'h3000, 32'h0, 32'h0F0F0F0F, 1'b0, 20);
        wait_done(60);

        // Reset on the 2nd BUSY cycle drops the transaction; ch0 is re-granted after release.
        lat[0] = 0;
        drive_req(0, 0, 1'b0, 32'h400, 32'h0);
        drive_req(0, 1, 1'b1, 32'h404, 32'hCAFE0404);
        push(0, 0, 1'b0, 32'h400, 32'h0, 32'h0, 1'b0, 0);
        step();
        step();
        check("pre_reset_busy", 64'(busy_cnt[0]), 64'd2);
        rst_n = 1'b0;
        sb.delete();
        step();
        check_zero(0, "midrst");
        rst_n     = 1'b1;
        lat[0]    = 2;
        mrdata[0] = 32'h44440000;
        push(0, 0, 1'b0, 32'h400, 32'h0, 32'h44440000, 1'b0, 2);
        push(0, 1, 1'b1, 32'h404, 32'hCAFE0404, 32'h44440000, 1'b0, 2);
        wait_done(40);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
